multi_input_logic_unit: RTL

MULTI_INPUT_LOGIC_UNIT -- requirements
Module: multi_input_logic_unit

---
 rtl/logic_unit_pkg.sv | 17 +
 rtl/button_debouncer.sv | 52 +++++
 rtl/multi_input_logic_unit.sv | 100 ++++++++++
 3 files changed

// File: rtl/logic_unit_pkg.sv
// Shared mode encoding for the multi-input logic unit.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    MODE_AND         = 3'd0,
    MODE_OR          = 3'd1,
    MODE_XOR         = 3'd2,
    MODE_NAND        = 3'd3,
    MODE_NOR         = 3'd4,
    MODE_XNOR        = 3'd5,
    MODE_AT_LEAST_K  = 3'd6,
    MODE_EXACTLY_ONE = 3'd7
  } mode_e;

  localparam int MODE_COUNT = 8;

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser plus optional debouncer for the mode push-button.
// The debouncer is built only when MULTI_INPUT_LOGIC_UNIT_DEBOUNCE_EN is defined.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic level
);

  logic s1, s2;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range 1..65535");
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= button;
      s2 <= s1;
    end
  end

`ifdef MULTI_INPUT_LOGIC_UNIT_DEBOUNCE_EN
  logic [15:0] cnt;
  logic        level_q;

  // Level follows s2 only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      level_q <= 1'b0;
    end else if (s2 == level_q) begin
      cnt <= '0;
    end else if (cnt == 16'(DEBOUNCE_CYCLES - 1)) begin
      level_q <= s2;
      cnt     <= '0;
    end else begin
      cnt <= cnt + 16'd1;
    end
  end

  assign level = level_q;
`else
  assign level = s2;
`endif

endmodule

// File: rtl/multi_input_logic_unit.sv
// Selectable reduction/threshold logic over N_INPUTS bits with a button-stepped mode.
// Define MULTI_INPUT_LOGIC_UNIT_DEBOUNCE_EN to include the button debouncer.
module multi_input_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int N_INPUTS        = 4,
  parameter int K_THRESHOLD     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [N_INPUTS-1:0]               in_bits,
  input  logic                              en,
  input  logic                              mode_next,
  output logic                              result,
  output logic [$clog2(N_INPUTS+1)-1:0]     ones_count,
  output logic [2:0]                        mode,
  output logic                              enabled
);

  localparam int CW = $clog2(N_INPUTS + 1);

  if (N_INPUTS < 2 || N_INPUTS > 8 || K_THRESHOLD < 1 || K_THRESHOLD > N_INPUTS)
  begin : g_bad_params
    $error("N_INPUTS or K_THRESHOLD out of range");
  end

  function automatic logic [CW-1:0] popcount(input logic [N_INPUTS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N_INPUTS; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  function automatic logic evaluate(input logic [N_INPUTS-1:0] v, input mode_e m);
    logic [CW-1:0] c;
    logic          r;
    c = popcount(v);
    case (m)
      MODE_AND:         r = &v;
      MODE_OR:          r = |v;
      MODE_XOR:         r = ^v;
      MODE_NAND:        r = ~&v;
      MODE_NOR:         r = ~|v;
      MODE_XNOR:        r = ~^v;
      MODE_AT_LEAST_K:  r = (c >= CW'(K_THRESHOLD));
      default:          r = (c == CW'(1));
    endcase
    return r;
  endfunction

  logic          level;
  logic          level_d;
  logic          rise;
  mode_e         mode_q;
  logic          result_p1;
  logic [CW-1:0] ones_count_p1;
  logic          vld_p1;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_button (
    .clock (clock),
    .reset (reset),
    .button(mode_next),
    .level (level)
  );

  assign rise = level & ~level_d;

  // Edge register always advances, so a press while disabled is consumed, not deferred.
  always_ff @(posedge clock) begin
    if (reset) begin
      level_d <= 1'b0;
      mode_q  <= MODE_AND;
    end else begin
      level_d <= level;
      if (rise && en) mode_q <= mode_e'(3'(mode_q + 3'd1));
    end
  end

  // Stage p1: evaluation uses the mode held before any step taken at this edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      result_p1     <= 1'b0;
      ones_count_p1 <= '0;
      vld_p1        <= 1'b0;
    end else begin
      vld_p1        <= en;
      result_p1     <= en & evaluate(in_bits, mode_q);
      ones_count_p1 <= en ? popcount(in_bits) : '0;
    end
  end

  assign result     = result_p1;
  assign ones_count = ones_count_p1;
  assign mode       = mode_q;
  assign enabled    = vld_p1;

endmodule
